mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit; sequential successor to the single-cycle ALU.
//   Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU selected by funct3.
//   Uses a valid/ready handshake on input and output. Sits beside the ALU in EX.
//   The pipeline stalls EX on busy. One op in flight; one quotient/product bit per cycle.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width W (>=8, even)
// PORTS
//   clk          in   1  clock, rising edge
//   rstN         in   1  asynchronous active-low reset
//   flush        in   1  sync abort of in-flight op (pipeline flush)
//   in_valid     in   1  operands/funct3 valid
//   in_ready     out  1  unit can accept (state IDLE)
//   funct3       in   3  000 mul,001 mulh,010 mulhsu,011 mulhu,100 div,101 divu,110 rem,111 remu
//   bus_a        in   W  rs1 operand (dividend / multiplicand)
//   bus_b        in   W  rs2 operand (divisor / multiplier)
//   out_valid    out  1  result valid (state DONE)
//   out_ready    in   1  consumer takes result
//   result       out  W  selected result
//   div_by_zero  out  1  div/rem op with bus_b==0; qualified by out_valid
//   overflow     out  1  signed div/rem with bus_a==MIN, bus_b==-1; qualified by out_valid
//   busy         out  1  state != IDLE
// BEHAVIOUR
// - Reset (rstN low, async): state IDLE, counter 0. in_ready=1. All other outputs 0.
//   An in-flight op is discarded.
// - FSM IDLE->CALC->DONE->IDLE. in_ready = (state==IDLE). out_valid = (state==DONE).
// - Accept on edge with in_valid&in_ready. Register funct3 and operand signs.
//   Register |a|, |b| per signedness: mul/mulh/div/rem both signed; mulhsu a signed only.
//   Normal op: IDLE->CALC.
// - Special cases skip CALC; IDLE->DONE on the accept edge (latency 1 cycle).
//   - b==0 (div/rem ops): quotient all-ones, remainder = a, div_by_zero=1.
//   - signed MIN/-1 (div/rem): quotient = MIN, remainder = 0, overflow=1.
// - CALC: exactly W cycles, counter 0..W-1, one bit per edge.
//   - mul: shift-add into a 2W accumulator.
//   - div: restoring shift-subtract; partial remainder W+1 bits.
//   On the edge with counter==W-1: sign fixup, select result, ->DONE.
//   Normal latency: out_valid high W+1 cycles after accept edge (33 for W=32).
// - Sign fixup:
//   - product negated if sign(a)^sign(b) under the op's signedness.
//   - quotient negated if sign(a)^sign(b).
//   - remainder takes sign of a.
//   Result: mul = low W; mulh/mulhsu/mulhu = high W; div/divu = Q; rem/remu = R. All modulo 2^W.
// - DONE: result and flags held stable until out_ready. On out_ready: ->IDLE, out_valid=0.
//   The next op is accepted at the earliest one cycle later; no same-cycle turnaround.
// - flush=1: ->IDLE next edge from any state; result/flags cleared; no out_valid.
//   flush has priority over accept and out_ready.
// - in_valid while not IDLE: ignored, no side effect.
// - Flags are 0 for mul ops and for non-special div ops.
// TESTING (W=32)
// - mul 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 33 cycles after accept.
// - mulh 0x80000000*0x80000000 -> 0x40000000.
//   mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//   mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
// - div 0xFFFFFFF9/2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF.
//   divu 100/7 -> 14; remu -> 2.
// - divu 5/0 -> 0xFFFFFFFF, div_by_zero=1, latency 1.
//   rem 5/0 -> 5.
//   div 0x80000000/0xFFFFFFFF -> 0x80000000, overflow=1; rem -> 0.
// - out_ready low 5 cycles in DONE -> result stable, in_ready=0, in_valid ignored.
//   Then release -> IDLE.
// - flush at CALC counter 10 -> IDLE next cycle, no out_valid.
//   rstN low mid-CALC -> immediate IDLE; next op after reset correct.

Source files
------------

// File: rtl/mul_div_if.sv
// Handshake and operand bus between the EX stage and the iterative multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface mul_div_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            funct3;
   logic [DATA_WIDTH-1:0] bus_a;
   logic [DATA_WIDTH-1:0] bus_b;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] result;
   logic                  div_by_zero;
   logic                  overflow;
   logic                  busy;

   modport master (
      output flush, in_valid, funct3, bus_a, bus_b, out_ready,
      input  in_ready, out_valid, result, div_by_zero, overflow, busy
   );

   modport slave (
      input  flush, in_valid, funct3, bus_a, bus_b, out_ready,
      output in_ready, out_valid, result, div_by_zero, overflow, busy
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: one product or quotient bit per cycle on magnitudes,
// with the sign applied on the last step. Divide-by-zero and MIN/-1 finish immediately.
//
//   state  | meaning
//   S_IDLE | waiting for an op, in_ready high
//   S_CALC | W shift-add / shift-subtract steps, cnt_q counts 0..W-1
//   S_DONE | result and flags held until out_ready
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rstN,
   mul_div_if.slave     bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            neg_res_q, neg_res_d;
   logic            neg_rem_q, neg_rem_d;
   logic [W-1:0]    opr_q, opr_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    result_q, result_d;
   logic            dbz_q, dbz_d;
   logic            ovf_q, ovf_d;

   logic            is_div, a_sgn, b_sgn, neg_a, neg_b;
   logic [W-1:0]    mag_a, mag_b;
   logic            b_zero, sgn_ovf;
   logic [W:0]      mul_sum, trial;
   logic [W-1:0]    diff;
   logic            ge;
   logic [2*W-1:0]  mul_next, div_next, step, prod_fix;
   logic [W-1:0]    q_fix, r_fix, res_sel;

   // Operand decode for the op presented at the input
   assign is_div  = bus.funct3[2];
   assign a_sgn   = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
   assign b_sgn   = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
   assign neg_a   = a_sgn & bus.bus_a[W-1];
   assign neg_b   = b_sgn & bus.bus_b[W-1];
   assign mag_a   = neg_a ? -bus.bus_a : bus.bus_a;
   assign mag_b   = neg_b ? -bus.bus_b : bus.bus_b;
   assign b_zero  = is_div & (bus.bus_b == '0);
   assign sgn_ovf = is_div & ~bus.funct3[0] & (bus.bus_a == {1'b1, {(W-1){1'b0}}}) & (&bus.bus_b);

   // Multiply: acc = {partial high, multiplier low}, add then shift right
   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opr_q} : '0);
   assign mul_next = {mul_sum, acc_q[W-1:1]};

   // Divide: acc = {partial remainder, dividend shifting into quotient}
   assign trial    = {acc_q[2*W-1:W], acc_q[W-1]};
   assign ge       = trial >= {1'b0, opr_q};
   assign diff     = trial[W-1:0] - opr_q;
   assign div_next = {(ge ? diff : trial[W-1:0]), acc_q[W-2:0], ge};

   assign step     = op_q[2] ? div_next : mul_next;
   assign prod_fix = neg_res_q ? -step : step;
   assign q_fix    = neg_res_q ? -step[W-1:0] : step[W-1:0];
   assign r_fix    = neg_rem_q ? -step[2*W-1:W] : step[2*W-1:W];

   always_comb begin
      res_sel = prod_fix[2*W-1:W];
      case (op_q)
         3'b000:         res_sel = prod_fix[W-1:0];
         3'b100, 3'b101: res_sel = q_fix;
         3'b110, 3'b111: res_sel = r_fix;
         default:        res_sel = prod_fix[2*W-1:W];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      opr_d     = opr_q;
      acc_d     = acc_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
      ovf_d     = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               op_d      = bus.funct3;
               neg_res_d = neg_a ^ neg_b;
               neg_rem_d = neg_a;
               opr_d     = is_div ? mag_b : mag_a;
               acc_d     = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
               cnt_d     = '0;
               dbz_d     = 1'b0;
               ovf_d     = 1'b0;
               if (b_zero) begin
                  result_d = bus.funct3[1] ? bus.bus_a : '1;
                  dbz_d    = 1'b1;
                  state_d  = S_DONE;
               end else if (sgn_ovf) begin
                  result_d = bus.funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                  ovf_d    = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W-1)) begin
               result_d = res_sel;
               cnt_d    = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pipeline flush wins over accept and out_ready
      if (bus.flush) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         result_d = '0;
         dbz_d    = 1'b0;
         ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opr_q     <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         opr_q     <= opr_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.out_valid   = (state_q == S_DONE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.result      = result_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: an arithmetic reference model checks every valid result,
// and each directed op also carries a hand-computed result, flag pair and latency.
module tb_mul_div_unit;
   localparam int W = 32;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   mul_div_if #(.DATA_WIDTH(W)) bus ();
   mul_div_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rstN(rstN), .bus(bus));

   int total = 0;
   int bad   = 0;

   logic         pending = 1'b0;
   logic [W-1:0] exp_res = '0;
   logic         exp_dbz = 1'b0;
   logic         exp_ovf = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference: plain 64-bit arithmetic following the RV32M definitions
   function automatic logic [W+1:0] model(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa, sb, ua, ub, p;
      logic [W-1:0] q, r, res;
      logic dz, ov;
      sa = $signed(a);
      sb = $signed(b);
      ua = {{W{1'b0}}, a};
      ub = {{W{1'b0}}, b};
      dz = 1'b0;
      ov = 1'b0;
      res = '0;
      case (f3)
         3'd0: begin p = sa * sb; res = p[W-1:0];   end
         3'd1: begin p = sa * sb; res = p[2*W-1:W]; end
         3'd2: begin p = sa * ub; res = p[2*W-1:W]; end
         3'd3: begin p = ua * ub; res = p[2*W-1:W]; end
         default: begin
            if (b == '0) begin
               q = '1; r = a; dz = 1'b1;
            end else if (!f3[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
               q = a; r = '0; ov = 1'b1;
            end else if (!f3[0]) begin
               p = sa / sb; q = p[W-1:0];
               p = sa % sb; r = p[W-1:0];
            end else begin
               q = a / b; r = a % b;
            end
            res = f3[1] ? r : q;
         end
      endcase
      return {dz, ov, res};
   endfunction

   // Compare process: every cycle out_valid is high the outputs must match the model
   always @(negedge clk) begin
      if (rstN && bus.out_valid) begin
         if (!pending) chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
         else begin
            chk("model_result", 64'(bus.result), 64'(exp_res));
            chk("model_dbz", 64'(bus.div_by_zero), 64'(exp_dbz));
            chk("model_ovf", 64'(bus.overflow), 64'(exp_ovf));
         end
      end
   end

   task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.funct3   = f3;
      bus.bus_a    = a;
      bus.bus_b    = b;
      @(posedge clk);
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lit, input logic [1:0] lit_flags, input int lat, input int hold);
      int  n;
      logic got;
      @(negedge clk);
      chk("in_ready_before", 64'(bus.in_ready), 64'd1);
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      bus.funct3    = f3;
      bus.bus_a     = a;
      bus.bus_b     = b;
      @(posedge clk);
      {exp_dbz, exp_ovf, exp_res} = model(f3, a, b);
      pending = 1'b1;
      n = 0;
      got = 1'b0;
      while (n < 100 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1) bus.in_valid = 1'b0;
         got = bus.out_valid;
      end
      if (!got) begin
         chk("timeout_out_valid", 64'd0, 64'd1);
         bus.out_ready = 1'b1;
      end else begin
         chk("latency", 64'(n), 64'(lat));
         chk("lit_result", 64'(bus.result), 64'(lit));
         chk("lit_flags", 64'({bus.div_by_zero, bus.overflow}), 64'(lit_flags));
         for (int i = 0; i < hold; i++) begin
            chk("hold_result", 64'(bus.result), 64'(lit));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            bus.in_valid = 1'b1;
            bus.funct3   = 3'd0;
            bus.bus_a    = 32'd123;
            bus.bus_b    = 32'd456;
            @(negedge clk);
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
      end
      @(posedge clk);
      pending = 1'b0;
      @(negedge clk);
      chk("idle_after", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.funct3    = '0;
      bus.bus_a     = '0;
      bus.bus_b     = '0;
      bus.out_ready = 1'b0;

      #12;
      chk("reset_outputs", 64'({bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero, bus.overflow}), 64'b10000);
      chk("reset_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      rstN = 1'b1;

      run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2'b00, 33, 0);
      run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2'b00, 33, 0);
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2'b00, 33, 0);
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 33, 0);
      run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 2'b00, 33, 0);
      run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 2'b00, 33, 0);
      run_op(3'd5, 32'd100,      32'd7,        32'd14,       2'b00, 33, 0);
      run_op(3'd7, 32'd100,      32'd7,        32'd2,        2'b00, 33, 0);
      run_op(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 2'b10, 1, 0);
      run_op(3'd6, 32'd5,        32'd0,        32'd5,        2'b10, 1, 0);
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2'b01, 1, 0);
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2'b01, 1, 0);
      run_op(3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2'b00, 33, 0);
      run_op(3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 2'b00, 33, 0);
      run_op(3'd6, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 2'b00, 33, 0);
      run_op(3'd4, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 2'b00, 33, 0);
      run_op(3'd6, 32'd100,      32'hFFFFFFF9, 32'd2,        2'b00, 33, 0);
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        2'b00, 33, 0);
      run_op(3'd2, 32'h80000000, 32'd2,        32'hFFFFFFFF, 2'b00, 33, 0);
      run_op(3'd0, 32'h12345678, 32'h10,       32'h23456780, 2'b00, 33, 0);
      run_op(3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 2'b00, 33, 0);
      run_op(3'd7, 32'h80000000, 32'h80000001, 32'h80000000, 2'b00, 33, 0);
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2'b00, 33, 5);

      // Flush while the counter sits at 10
      start_op(3'd0, 32'd3, 32'd5);
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         if (n == 1) bus.in_valid = 1'b0;
      end
      chk("busy_before_flush", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_state", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
      chk("flush_result", 64'(bus.result), 64'd0);
      repeat (40) @(negedge clk);
      chk("flush_no_valid", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset in the middle of a calculation
      start_op(3'd4, 32'd1000, 32'd3);
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (n == 1) bus.in_valid = 1'b0;
      end
      #2 rstN = 1'b0;
      #1;
      chk("async_reset_state", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
      chk("async_reset_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      run_op(3'd4, 32'd1000, 32'd3, 32'd333, 2'b00, 33, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
